// File: rtl/dcache_wt_if.sv
// Core-side and memory-side signal bundle for the write-through data cache.
// The slave modport is the cache view; master is the core/memory (testbench) view.
interface dcache_wt_if;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  modport slave (
    input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, one-word-line data cache; write-through, no-write-allocate,
// single outstanding backing-memory request.
module dcache_wt #(
  parameter int LINES = 16
) (
  input  logic       clk,
  input  logic       rst,
  dcache_wt_if.slave bus
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e            state_q, state_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic [TW-1:0]     tag_q  [LINES];
  logic [31:0]       data_q [LINES];
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       hit_q, hit_d;
  logic [15:0]       miss_q, miss_d;

  logic [IW-1:0]     cpu_idx, reg_idx;
  logic [TW-1:0]     cpu_tag, reg_tag;
  logic              cpu_hit, reg_hit;
  logic              line_we;
  logic [31:0]       line_data;
  logic              stall;
  logic [31:0]       rdata;

  assign cpu_idx = bus.cpu_addr[IW+1:2];
  assign cpu_tag = bus.cpu_addr[31:IW+2];
  assign reg_idx = mem_addr_q[IW+1:2];
  assign reg_tag = mem_addr_q[31:IW+2];
  assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign reg_hit = valid_q[reg_idx] && (tag_q[reg_idx] == reg_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_d       = hit_q;
    miss_d      = miss_q;
    line_we     = 1'b0;
    line_data   = bus.mem_rdata;
    stall       = 1'b0;
    rdata       = 32'd0;
    unique case (state_q)
      IDLE: begin
        // Store wins over a simultaneous load; mem_ack is ignored here.
        if (bus.cpu_write) begin
          stall       = 1'b1;
          mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
          mem_wdata_d = bus.cpu_wdata;
          mem_we_d    = 1'b1;
          mem_req_d   = 1'b1;
          state_d     = WRITE;
        end else if (bus.cpu_read) begin
          if (cpu_hit) begin
            rdata = data_q[cpu_idx];
            if (hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
          end else begin
            stall      = 1'b1;
            mem_addr_d = {bus.cpu_addr[31:2], 2'b00};
            mem_we_d   = 1'b0;
            mem_req_d  = 1'b1;
            state_d    = FILL;
            if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
          end
        end
      end
      FILL: begin
        stall = !bus.mem_ack;
        if (bus.mem_ack) begin
          rdata            = bus.mem_rdata;
          line_we          = 1'b1;
          valid_d[reg_idx] = 1'b1;
          mem_req_d        = 1'b0;
          state_d          = IDLE;
        end
      end
      WRITE: begin
        stall = !bus.mem_ack;
        if (bus.mem_ack) begin
          line_we   = reg_hit;
          line_data = mem_wdata_q;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      hit_q       <= 16'd0;
      miss_q      <= 16'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  // Tag/data arrays carry no reset; line_we is only raised out of FILL/WRITE.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[reg_idx]  <= reg_tag;
      data_q[reg_idx] <= line_data;
    end
  end

  assign bus.stall     = rst ? 1'b0  : stall;
  assign bus.cpu_rdata = rst ? 32'd0 : rdata;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_q;
  assign bus.miss_cnt  = miss_q;
endmodule

// File: tb/tb_dcache_wt.sv
// Random load/store traffic against a line-level cache model and a word-addressed memory model.
module tb_dcache_wt;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_wt_if bus ();
  dcache_wt #(.LINES(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  // reference model: per-line valid/tag/data, backing memory, load statistics
  bit            mv [16];
  logic [25:0]   mt [16];
  logic [31:0]   md [16];
  logic [31:0]   mem [logic [29:0]];
  int            m_hit = 0;
  int            m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (!mem.exists(a[31:2])) mem[a[31:2]] = $urandom;
    return mem[a[31:2]];
  endfunction

  task automatic chk_cnt();
    chk("hit_cnt", {16'd0, bus.hit_cnt}, m_hit[31:0]);
    chk("miss_cnt", {16'd0, bus.miss_cnt}, m_miss[31:0]);
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_load(input logic [31:0] a, input int lat);
    logic [3:0]  idx = a[5:2];
    logic [25:0] tg  = a[31:6];
    logic [31:0] v;
    int          stalls = 0;
    bus.cpu_read = 1'b1; bus.cpu_write = 1'b0; bus.cpu_addr = a;
    @(negedge clk);
    if (mv[idx] && mt[idx] == tg) begin
      chk("ld_hit_stall", {31'd0, bus.stall}, 32'd0);
      chk("ld_hit_data", bus.cpu_rdata, md[idx]);
      @(posedge clk); #1;
      m_hit++;
      chk("ld_hit_noreq", {31'd0, bus.mem_req}, 32'd0);
    end else begin
      v = mem_rd(a);
      if (bus.stall) stalls++;
      chk("ld_miss_rdata0", bus.cpu_rdata, 32'd0);
      @(posedge clk); #1;
      m_miss++;
      chk("fill_req", {30'd0, bus.mem_req, bus.mem_we}, 32'd2);
      chk("fill_addr", bus.mem_addr, {a[31:2], 2'b00});
      repeat (lat) begin
        bus.mem_rdata = $urandom;
        @(negedge clk);
        if (bus.stall) stalls++;
        chk("fill_wait_rdata0", bus.cpu_rdata, 32'd0);
        chk("fill_hold", bus.mem_addr, {a[31:2], 2'b00});
        @(posedge clk); #1;
      end
      chk("fill_stall_cycles", stalls, lat + 1);
      bus.mem_ack = 1'b1; bus.mem_rdata = v;
      @(negedge clk);
      chk("fill_ack_stall", {31'd0, bus.stall}, 32'd0);
      chk("fill_bypass", bus.cpu_rdata, v);
      chk("fill_ack_req", {31'd0, bus.mem_req}, 32'd1);
      @(posedge clk); #1;
      bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      chk("fill_done_req", {31'd0, bus.mem_req}, 32'd0);
      mv[idx] = 1'b1; mt[idx] = tg; md[idx] = v;
    end
    bus.cpu_read = 1'b0;
    chk_cnt();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int lat, input bit rd_too);
    logic [3:0]  idx = a[5:2];
    logic [25:0] tg  = a[31:6];
    bus.cpu_write = 1'b1; bus.cpu_read = rd_too; bus.cpu_addr = a; bus.cpu_wdata = d;
    @(negedge clk);
    chk("st_stall", {31'd0, bus.stall}, 32'd1);
    chk("st_rdata0", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    bus.cpu_wdata = $urandom;
    chk("wr_req", {30'd0, bus.mem_req, bus.mem_we}, 32'd3);
    chk("wr_addr", bus.mem_addr, {a[31:2], 2'b00});
    chk("wr_data", bus.mem_wdata, d);
    repeat (lat) begin
      @(negedge clk);
      chk("wr_wait_stall", {31'd0, bus.stall}, 32'd1);
      chk("wr_hold", bus.mem_wdata, d);
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("wr_ack_stall", {31'd0, bus.stall}, 32'd0);
    chk("wr_ack_hold", {bus.mem_addr[31:1], bus.mem_we}, {a[31:2], 2'b01});
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("wr_done_req", {31'd0, bus.mem_req}, 32'd0);
    mem[a[31:2]] = d;
    if (mv[idx] && mt[idx] == tg) md[idx] = d;
    bus.cpu_write = 1'b0; bus.cpu_read = 1'b0;
    chk_cnt();
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_hit = 0; m_miss = 0;
  endtask

  initial begin
    bus.cpu_read = 1'b0; bus.cpu_write = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    rst = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_stall", {31'd0, bus.stall}, 32'd0);
    chk_cnt();
    rst = 1'b0;

    // cold miss, repeat hit, store-hit update
    mem[30'h10] = 32'hDEADBEEF;
    do_load(32'h40, 3);
    do_load(32'h40, 0);
    do_store(32'h40, 32'h12345678, 2, 1'b0);
    do_load(32'h40, 0);
    // conflict on index 0, then original address misses again
    do_load(32'h80, 1);
    do_load(32'h40, 1);
    // no-write-allocate
    do_store(32'h100, 32'hCAFEF00D, 1, 1'b0);
    do_load(32'h100, 2);
    // write priority over a simultaneous read
    do_store(32'h44, 32'hA5A5A5A5, 0, 1'b1);

    // ack while idle is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    chk("idle_ack_stall", {31'd0, bus.stall}, 32'd0);
    chk("idle_ack_rdata", bus.cpu_rdata, 32'd0);
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, bus.mem_req}, 32'd0);

    // reset in the middle of a fill
    bus.cpu_read = 1'b1; bus.cpu_addr = 32'hC40;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    reset_model();
    chk("async_rst_req", {31'd0, bus.mem_req}, 32'd0);
    chk("async_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("async_rst_rdata", bus.cpu_rdata, 32'd0);
    chk_cnt();
    bus.cpu_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_load(32'h40, 1);

    // random traffic over a small address pool to get hits, conflicts and misses
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      case ($urandom_range(0, 3))
        0:       do_store(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        1:       begin @(posedge clk); #1; end
        default: do_load(a, $urandom_range(0, 3));
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
